// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile_sb register file slice.
package regfile_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: a load reservation sets a bit and the matching writeback clears it.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q1,
  output logic          q2
);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // The set is applied after the clear, so a new producer on the same edge supersedes the old one.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != AW'(REG_ZERO))) begin
      pending_d[set_addr] = 1'b1;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else if (run) begin
      pending_q <= pending_d;
    end
  end

  assign q1 = run & pending_q[q_addr1];
  assign q2 = run & pending_q[q_addr2];

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with a post-reset clearing sweep and a load scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH,
  parameter  int DEPTH = RF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we3,
  input  logic [AW-1:0]    a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             pend1,
  output logic             pend2,
  output logic             ready
);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             run;
  logic             sb_q1, sb_q2;
  logic             byp1, byp2;

  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Storage has no reset of its own; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (we3 && (a3 != AW'(REG_ZERO))) begin
        mem_q[a3] <= wd3;
      end
    end
  end

  rf_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .set_en   (rsv_en),
    .set_addr (rsv_addr),
    .clr_en   (we3),
    .clr_addr (a3),
    .q_addr1  (a1),
    .q_addr2  (a2),
    .q1       (sb_q1),
    .q2       (sb_q2)
  );

`ifdef REGFILE_BYPASS_EN
  assign byp1 = we3 && (a3 != AW'(REG_ZERO)) && (a3 == a1);
  assign byp2 = we3 && (a3 != AW'(REG_ZERO)) && (a3 == a2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign rd1 = (!run || (a1 == AW'(REG_ZERO))) ? '0 : (byp1 ? wd3 : mem_q[a1]);
  assign rd2 = (!run || (a2 == AW'(REG_ZERO))) ? '0 : (byp2 ? wd3 : mem_q[a2]);

  assign pend1 = sb_q1 & ~byp1;
  assign pend2 = sb_q2 & ~byp2;
  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: default 32x32 instance plus a 16x8 instance.
module tb_regfile_sb;

  logic        clk;
  int          vectors;
  int          miscompares;

  logic        rst, we3, rsv_en;
  logic [4:0]  a1, a2, a3, rsv_addr;
  logic [31:0] wd3, rd1, rd2;
  logic        pend1, pend2, ready;

  logic        s_rst, s_we3, s_rsv_en;
  logic [3:0]  s_a1, s_a2, s_a3, s_rsv_addr;
  logic [7:0]  s_wd3, s_rd1, s_rd2;
  logic        s_pend1, s_pend2, s_ready;

  regfile_sb dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .a3(a3), .wd3(wd3), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend1(pend1), .pend2(pend2), .ready(ready)
  );

  regfile_sb #(.WIDTH(8), .DEPTH(16)) u_small (
    .clk(clk), .rst(s_rst), .a1(s_a1), .a2(s_a2), .rd1(s_rd1), .rd2(s_rd2),
    .we3(s_we3), .a3(s_a3), .wd3(s_wd3), .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
    .pend1(s_pend1), .pend2(s_pend2), .ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and step clear of it before touching inputs.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; we3 = 1'b0; rsv_en = 1'b0;
    a1 = 5'd7; a2 = 5'd0; a3 = 5'd0; rsv_addr = 5'd0; wd3 = 32'h0;
    s_rst = 1'b1; s_we3 = 1'b0; s_rsv_en = 1'b0;
    s_a1 = 4'd0; s_a2 = 4'd0; s_a3 = 4'd0; s_rsv_addr = 4'd0; s_wd3 = 8'h0;

    // Reset held for two edges
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("reset_ready", {31'b0, ready}, 32'd0);
    checkOutput("reset_rd1_a7", rd1, 32'd0);
    checkOutput("reset_pend1", {31'b0, pend1}, 32'd0);
    rst = 1'b0;

    // Partial sweep, interrupted by reset on its 10th edge
    for (int i = 0; i < 9; i++) begin
      applyStimulus();
      checkOutput("sweep1_ready", {31'b0, ready}, 32'd0);
    end
    rst = 1'b1;
    applyStimulus();
    checkOutput("midsweep_rst_ready", {31'b0, ready}, 32'd0);
    rst = 1'b0;

    // Full sweep with writes and reservations that must be ignored
    we3 = 1'b1; a3 = 5'd4; wd3 = 32'hFF;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    a1 = 5'd4; a2 = 5'd4;
    for (int i = 0; i < 32; i++) begin
      applyStimulus();
      if (i == 31) begin
        we3 = 1'b0;
        rsv_en = 1'b0;
        #1;
      end
      checkOutput("sweep2_ready", {31'b0, ready}, (i == 31) ? 32'd1 : 32'd0);
      if (i < 31) begin
        checkOutput("init_rd1", rd1, 32'd0);
        checkOutput("init_pend2", {31'b0, pend2}, 32'd0);
      end
    end
    checkOutput("iso_rd1", rd1, 32'd0);
    checkOutput("iso_pend1", {31'b0, pend1}, 32'd0);

    // Write / read
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
    applyStimulus();
    we3 = 1'b0; a1 = 5'd5; a2 = 5'd5;
    #1;
    checkOutput("wr5_rd1", rd1, 32'hDEADBEEF);
    checkOutput("wr5_rd2", rd2, 32'hDEADBEEF);
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234;
    applyStimulus();
    we3 = 1'b0; a2 = 5'd0;
    #1;
    checkOutput("wr0_rd2", rd2, 32'd0);
    checkOutput("wr0_keep5", rd1, 32'hDEADBEEF);

    // Scoreboard set, clear, same-edge, duplicate, register 0
    rsv_en = 1'b1; rsv_addr = 5'd9;
    applyStimulus();
    rsv_en = 1'b0; a1 = 5'd9; a2 = 5'd9;
    #1;
    checkOutput("rsv9_pend1", {31'b0, pend1}, 32'd1);
    checkOutput("rsv9_pend2", {31'b0, pend2}, 32'd1);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    applyStimulus();
    rsv_en = 1'b0;
    #1;
    checkOutput("rsv9_dup", {31'b0, pend1}, 32'd1);
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h77; a1 = 5'd9;
    applyStimulus();
    we3 = 1'b0;
    #1;
    checkOutput("clr9_pend1", {31'b0, pend1}, 32'd0);
    checkOutput("clr9_rd1", rd1, 32'h77);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'h88;
    applyStimulus();
    rsv_en = 1'b0; we3 = 1'b0;
    #1;
    checkOutput("same_edge_pend1", {31'b0, pend1}, 32'd1);
    checkOutput("same_edge_rd1", rd1, 32'h88);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    applyStimulus();
    rsv_en = 1'b0; a1 = 5'd0;
    #1;
    checkOutput("rsv0_pend1", {31'b0, pend1}, 32'd0);

    // Same-cycle write vs read
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h11;
    applyStimulus();
    a3 = 5'd3; wd3 = 32'h22; a1 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass_same_cycle", rd1, 32'h22);
`else
    checkOutput("nobypass_same_cycle", rd1, 32'h11);
`endif
    applyStimulus();
    we3 = 1'b0;
    #1;
    checkOutput("write_next_cycle", rd1, 32'h22);

    // Small instance: 16-entry sweep, then a single write at the top entry
    applyStimulus();
    s_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      checkOutput("small_sweep_ready", {31'b0, s_ready}, (i == 15) ? 32'd1 : 32'd0);
    end
    s_we3 = 1'b1; s_a3 = 4'd15; s_wd3 = 8'hA5;
    applyStimulus();
    s_we3 = 1'b0;
    for (int r = 0; r < 16; r++) begin
      s_a1 = 4'(r);
      #1;
      checkOutput("small_read", {24'b0, s_rd1}, (r == 15) ? 32'hA5 : 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
